// File: rtl/acc_pkg.sv
// Shared constants and clear-sequencer state encoding for the accumulator port.
package acc_pkg;
    localparam int ACC_DATA_W = 32;
    localparam int ACC_ADDR_W = 8;
    localparam int ACC_DEPTH  = 256;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } clr_state_t;
endpackage

// File: rtl/acc_clear_seq.sv
// Sequential zero-fill engine: one address per unstalled cycle, busy/complete registered.
// Stalled cycles hold the current address; a held request starts exactly one pass.
module acc_clear_seq
    import acc_pkg::*;
#(
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int DEPTH  = ACC_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    input  logic              stall_i,
    output logic              clr_busy_o,
    output logic              clr_complete_o,
    output logic [ADDR_W-1:0] clr_addr_o
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              armed_q, armed_d;
    logic              busy_q, complete_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        armed_d = armed_q;
        // Re-arm only once the request has been seen low.
        if (!clr_req_i) begin
            armed_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (clr_req_i && armed_q) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    armed_d = 1'b0;
                end
            end
            CLEAR: begin
                if (!stall_i) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            armed_q    <= 1'b1;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            armed_q    <= armed_d;
            busy_q     <= (state_d == CLEAR);
            complete_q <= (state_d == DONE);
        end
    end

    assign clr_busy_o     = busy_q;
    assign clr_complete_o = complete_q;
    assign clr_addr_o     = addr_q;
endmodule

// File: rtl/acc_port_arbiter.sv
// Single-port accumulator RAM arbiter: systolic write > clear > host read, mux is combinational.
// Read data valid one cycle after grant; reads wait out writes and clears, writes never stall.
module acc_port_arbiter
    import acc_pkg::*;
#(
    parameter int DATA_W = ACC_DATA_W,
    parameter int ADDR_W = ACC_ADDR_W,
    parameter int DEPTH  = ACC_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sys_wr_en,
    input  logic [ADDR_W-1:0] sys_wr_addr,
    input  logic [DATA_W-1:0] sys_wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_complete,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wr_collide_err
);
    logic              clr_busy_w;
    logic [ADDR_W-1:0] clr_addr_w;
    logic              rd_valid_q;
    logic              collide_q;

    acc_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clk            (clk),
        .rst            (rst),
        .clr_req_i      (clr_req),
        .stall_i        (sys_wr_en),
        .clr_busy_o     (clr_busy_w),
        .clr_complete_o (clr_complete),
        .clr_addr_o     (clr_addr_w)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (sys_wr_en) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = sys_wr_addr;
            mem_wdata = sys_wr_data;
        end else if (clr_busy_w) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr_w;
        end else if (rd_req) begin
            mem_en    = 1'b1;
            mem_addr  = rd_addr;
        end
    end

    assign rd_gnt = rd_req && !sys_wr_en && !clr_busy_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            collide_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_gnt;
            collide_q  <= collide_q | (sys_wr_en & clr_busy_w);
        end
    end

    // RAM output arrives in the cycle after the grant; zero it outside that cycle.
    assign rd_data        = rd_valid_q ? mem_rdata : '0;
    assign rd_valid       = rd_valid_q;
    assign clr_busy       = clr_busy_w;
    assign wr_collide_err = collide_q;
endmodule

// File: tb/tb_acc_port_arbiter.sv
// Directed bench for acc_port_arbiter with a behavioural single-port RAM behind it.
module tb_acc_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        sys_wr_en;
    logic [7:0]  sys_wr_addr;
    logic [31:0] sys_wr_data;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_complete;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_gnt;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        wr_collide_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram [256];

    always #5 clk = ~clk;

    acc_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .sys_wr_en      (sys_wr_en),
        .sys_wr_addr    (sys_wr_addr),
        .sys_wr_data    (sys_wr_data),
        .clr_req        (clr_req),
        .clr_busy       (clr_busy),
        .clr_complete   (clr_complete),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_gnt         (rd_gnt),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .wr_collide_err (wr_collide_err)
    );

    // Non-zero fill during reset so that zero-writes are observable.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'hA500_0000 | 32'(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int nz;
        int gnt_at;

        rst = 1'b1; sys_wr_en = 1'b0; sys_wr_addr = '0; sys_wr_data = '0;
        clr_req = 1'b0; rd_req = 1'b0; rd_addr = '0;
        repeat (3) step();
        at_neg();
        check("rst_busy", clr_busy, 0);
        check("rst_complete", clr_complete, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_err", wr_collide_err, 0);
        check("rst_mem_en", mem_en, 0);
        step();
        rst = 1'b0;
        step();

        // Clear with a 3-cycle request pulse: one full pass, no retrigger.
        clr_req = 1'b1;
        at_neg();
        check("clr1_idle_busy", clr_busy, 0);
        step();
        bad = 0;
        for (int k = 1; k <= 262; k++) begin
            if (k == 3) clr_req = 1'b0;
            at_neg();
            if (k <= 256) begin
                if (!(mem_en && mem_we && mem_addr == 8'(k - 1) && mem_wdata == 0
                      && clr_busy && !clr_complete)) bad++;
            end else if (k == 257) begin
                check("clr1_done_pulse", clr_complete, 1);
                check("clr1_busy_low", clr_busy, 0);
            end else begin
                if (clr_busy || clr_complete || mem_en) bad++;
            end
            step();
        end
        check("clr1_bad_cycles", bad, 0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (ram[i] != 0) nz++;
        check("clr1_ram_nonzero", nz, 0);
        check("clr1_no_err", wr_collide_err, 0);

        // Clear preempted by three systolic writes at clr_addr 10.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 1; k <= 262; k++) begin
            sys_wr_en   = (k >= 11 && k <= 13);
            sys_wr_addr = 8'(k - 6);
            sys_wr_data = 32'hDEAD;
            at_neg();
            if (k == 11) begin
                check("pre_wr_addr", mem_addr, 5);
                check("pre_wr_data", mem_wdata, 32'hDEAD);
            end
            if (k == 14) begin
                check("pre_held_addr", mem_addr, 10);
                check("pre_held_data", mem_wdata, 0);
            end
            if (k == 259) check("pre_busy_259", clr_busy, 1);
            if (k == 260) begin
                check("pre_done_260", clr_complete, 1);
                check("pre_busy_260", clr_busy, 0);
            end
            step();
        end
        sys_wr_en = 1'b0;
        check("pre_err", wr_collide_err, 1);
        check("pre_ram10", ram[10], 0);
        check("pre_ram5", ram[5], 32'hDEAD);
        check("pre_ram7", ram[7], 32'hDEAD);

        // Write then back-to-back reads.
        sys_wr_en = 1'b1; sys_wr_addr = 8'h20; sys_wr_data = 32'h1234;
        step();
        sys_wr_en = 1'b0; rd_req = 1'b1; rd_addr = 8'h20;
        at_neg();
        check("rd_gnt", rd_gnt, 1);
        check("rd_mem_we", mem_we, 0);
        check("rd_mem_addr", mem_addr, 8'h20);
        step();
        rd_addr = 8'h05;
        at_neg();
        check("rd_valid1", rd_valid, 1);
        check("rd_data1", rd_data, 32'h1234);
        check("rd_gnt2", rd_gnt, 1);
        step();
        rd_req = 1'b0;
        at_neg();
        check("rd_valid2", rd_valid, 1);
        check("rd_data2", rd_data, 32'hDEAD);
        step();
        at_neg();
        check("rd_valid_off", rd_valid, 0);
        check("rd_data_off", rd_data, 0);
        step();

        // Read held across four systolic writes; first one hits the same address.
        rd_req = 1'b1; rd_addr = 8'h20; sys_wr_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            sys_wr_addr = (k == 1) ? 8'h20 : 8'(8'h30 + k);
            sys_wr_data = (k == 1) ? 32'h5678 : 32'(32'h1111 * k);
            at_neg();
            check("blk_gnt_low", rd_gnt, 0);
            step();
        end
        sys_wr_en = 1'b0;
        at_neg();
        check("blk_gnt_5", rd_gnt, 1);
        step();
        rd_req = 1'b0;
        at_neg();
        check("blk_valid", rd_valid, 1);
        check("blk_data", rd_data, 32'h5678);
        step();

        // Read during clear waits for busy to fall; request held through DONE.
        clr_req = 1'b1;
        step();
        rd_req = 1'b1; rd_addr = 8'h32;
        gnt_at = 0;
        for (int k = 1; k <= 300 && gnt_at == 0; k++) begin
            at_neg();
            if (rd_gnt) gnt_at = k;
            else        step();
        end
        check("clr_rd_gnt_cycle", gnt_at, 257);
        step();
        rd_req = 1'b0;
        at_neg();
        check("clr_rd_valid", rd_valid, 1);
        check("clr_rd_data", rd_data, 0);
        repeat (5) step();
        at_neg();
        check("clr_no_rearm", clr_busy, 0);
        step();
        clr_req = 1'b0;
        step();

        // Asynchronous reset mid-clear at clr_addr 100.
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (100) step();
        at_neg();
        check("rst_mid_addr", mem_addr, 100);
        check("rst_mid_busy", clr_busy, 1);
        check("rst_mid_err_set", wr_collide_err, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", clr_busy, 0);
        check("arst_complete", clr_complete, 0);
        check("arst_err", wr_collide_err, 0);
        check("arst_rd_valid", rd_valid, 0);
        check("arst_mem_en", mem_en, 0);
        bad = 0;
        repeat (3) begin
            step();
            if (clr_complete) bad++;
        end
        rst = 1'b0;
        repeat (4) begin
            step();
            if (clr_complete || clr_busy) bad++;
        end
        check("arst_no_complete", bad, 0);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        at_neg();
        check("restart_addr0", mem_addr, 0);
        check("restart_busy", clr_busy, 1);
        step();
        at_neg();
        check("restart_addr1", mem_addr, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
